// File: rtl/cory_route4_pkg.sv
// Shared constants and state encoding for the four-port static permutation controller.
// The selector width is fixed at two bits, giving four router ports.
package cory_route4_pkg;

   localparam int S     = 2;
   localparam int RATIO = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // Output zk selects input k: z0=0, z1=1, z2=2, z3=3.
   localparam logic [RATIO*S-1:0] IDENT_SEL = 8'b11_10_01_00;

endpackage

// File: rtl/cory_perm_chk.sv
// Combinational check that four packed two-bit selectors are pairwise distinct,
// which means they form a permutation of {0,1,2,3}.
module cory_perm_chk
   import cory_route4_pkg::*;
(
   input  logic [RATIO*S-1:0] sel,
   output logic               ok
);

   always_comb begin
      ok = 1'b1;
      for (int a = 0; a < RATIO; a++) begin
         for (int b = a + 1; b < RATIO; b++) begin
            if (sel[a*S +: S] == sel[b*S +: S]) ok = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cory_route4_perm.sv
// Loads a validated selector permutation into a 4-port router once it is idle, then counts
// per-port beats until every port has moved n beats. Optional: CORY_ROUTE4_PERM_OVF_EN.
module cory_route4_perm #(
   parameter int W = 8,
   parameter int S = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           i_c_v,
   input  logic [4*S-1:0] i_c_d,
   input  logic [W-1:0]   i_c_n,
   output logic           o_c_r,
   input  logic [3:0]     i_m_v,
   input  logic [3:0]     i_m_r,
   input  logic           i_idle,
   output logic [S-1:0]   o_z0_s,
   output logic [S-1:0]   o_z1_s,
   output logic [S-1:0]   o_z2_s,
   output logic [S-1:0]   o_z3_s,
   output logic           o_act,
   output logic           o_err
);

   import cory_route4_pkg::state_t, cory_route4_pkg::ST_IDLE, cory_route4_pkg::ST_WAIT,
          cory_route4_pkg::ST_RUN, cory_route4_pkg::IDENT_SEL, cory_route4_pkg::RATIO;

   state_t         state;
   logic [4*S-1:0] sel_q;
   logic [4*S-1:0] pend_d;
   logic [W-1:0]   pend_n;
   logic [W-1:0]   cnt [RATIO];
   logic           perm_ok;
   logic [3:0]     hs;
   logic [3:0]     sat;
   logic           all_done;

   cory_perm_chk u_perm_chk (
      .sel (i_c_d),
      .ok  (perm_ok)
   );

   assign hs = i_m_v & i_m_r;

   always_comb begin
      sat = '0;
      for (int k = 0; k < RATIO; k++) sat[k] = (cnt[k] == pend_n);
      all_done = &sat;
   end

`ifdef CORY_ROUTE4_PERM_OVF_EN
   logic ovf;
   assign ovf = |(hs & sat);
`endif

   // Selectors only move on the WAIT exit so the router never sees a switch mid-traffic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         sel_q  <= IDENT_SEL;
         pend_d <= '0;
         pend_n <= '0;
         for (int k = 0; k < RATIO; k++) cnt[k] <= '0;
         o_c_r  <= 1'b1;
         o_act  <= 1'b0;
         o_err  <= 1'b0;
      end else begin
         o_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_c_v) begin
                  if (perm_ok) begin
                     pend_d <= i_c_d;
                     pend_n <= i_c_n;
                     state  <= ST_WAIT;
                     o_c_r  <= 1'b0;
                  end else begin
                     o_err <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (i_idle) begin
                  sel_q <= pend_d;
                  for (int k = 0; k < RATIO; k++) cnt[k] <= '0;
                  if (pend_n == '0) begin
                     state <= ST_IDLE;
                     o_c_r <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                     o_act <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               // Saturate at n so a late handshake never wraps a full-range count.
               for (int k = 0; k < RATIO; k++) begin
                  if (hs[k] && !sat[k]) cnt[k] <= cnt[k] + 1'b1;
               end
`ifdef CORY_ROUTE4_PERM_OVF_EN
               if (ovf) o_err <= 1'b1;
`endif
               if (all_done) begin
                  state <= ST_IDLE;
                  o_act <= 1'b0;
                  o_c_r <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               o_act <= 1'b0;
               o_c_r <= 1'b1;
            end
         endcase
      end
   end

   assign o_z0_s = sel_q[0*S +: S];
   assign o_z1_s = sel_q[1*S +: S];
   assign o_z2_s = sel_q[2*S +: S];
   assign o_z3_s = sel_q[3*S +: S];

endmodule

// File: doc/cory_route4_perm.md
CORY_ROUTE4_PERM -- requirements
Module: cory_route4_perm

Interface
REQ-001 Parameter W, default 8: width of the beat-count field in a routing command.
REQ-002 Parameter S, default 2: selector width; fixed at 2 (four ports); other values unsupported.
REQ-003 clk  input  1  single clock; all state rises on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_c_v  input  1  routing command valid.
REQ-006 i_c_d  input  4*S  packed selectors: [1:0]=z0, [3:2]=z1, [5:4]=z2, [7:6]=z3.
REQ-007 i_c_n  input  W  beats each output port must transfer under this command.
REQ-008 o_c_r  output  1  command ready.
REQ-009 i_m_v  input  4  per-output valid, bit k = router output zk valid, monitor only.
REQ-010 i_m_r  input  4  per-output ready, bit k = router output zk ready, monitor only.
REQ-011 i_idle  input  1  router holds no valid on any input or output.
REQ-012 o_z0_s..o_z3_s  output  S each  static selectors driven to the router's zk_s inputs.
REQ-013 o_act  output  1  command in progress (RUN state).
REQ-014 o_err  output  1  one-cycle error pulse.

Function
REQ-015 States SHALL be IDLE, WAIT, RUN.
REQ-016 IDLE: o_c_r=1; other states: o_c_r=0.
REQ-017 Command accept = i_c_v & o_c_r.
REQ-018 On accept, the four selectors SHALL be checked as a permutation of {0,1,2,3}. If any two are equal, o_err=1 for the next cycle, the command is dropped, and the state stays IDLE.
REQ-019 On accepting a valid permutation, i_c_d and i_c_n SHALL be captured into pending registers; next state is WAIT.
REQ-020 WAIT: while i_idle=0, selectors stay unchanged. In the first cycle with i_idle=1, o_zk_s take the pending values on the next edge, all four counters clear, and the state moves to RUN; if pending n=0, the state moves to IDLE instead.
REQ-021 RUN: counter k increments on each cycle with i_m_v[k]&i_m_r[k] and saturates at n; o_act=1.
REQ-022 RUN exit: the cycle after all four counters equal n, the state moves to IDLE; o_zk_s keep their values.
REQ-023 Command-to-selector latency SHALL be at least 2 cycles (accept, then WAIT with i_idle=1); selectors never change outside the WAIT->RUN/IDLE transition.
REQ-024 A handshake in the same cycle a counter reaches n SHALL count; handshakes after saturation are not counted.
REQ-025 i_m_v/i_m_r SHALL be ignored in IDLE and WAIT.
REQ-026 Counters are W bits wide; n=2^W-1 SHALL be supported without wrap.

Reset
REQ-027 While reset=1: state=IDLE; o_z0_s=0, o_z1_s=1, o_z2_s=2, o_z3_s=3 (identity); counters and pending registers = 0; o_act=0; o_err=0; o_c_r=1 once state is IDLE.
REQ-028 Reset mid-RUN or mid-WAIT SHALL discard the command immediately, with no o_err pulse.

Configuration
REQ-029 Macro CORY_ROUTE4_PERM_OVF_EN defined: in RUN, a handshake on port k whose counter already equals n SHALL pulse o_err the next cycle, with no state change.
REQ-030 Macro undefined: overflow handshakes are silently ignored; o_err reports only invalid permutations.

Structure
REQ-031 Package cory_route4_pkg SHALL hold S=2, RATIO=4, the IDLE/WAIT/RUN state encoding, and the identity selector constant.
REQ-032 Sub-module cory_perm_chk SHALL be the combinational four-selector distinctness check, instantiated once.

Verification
REQ-033 After reset, check o_zk_s=0,1,2,3, o_c_r=1, o_act=0.
REQ-034 Command d=8'b00_01_10_11 (z0=3, z1=2, z2=1, z3=0), n=3, i_idle=1, three handshakes per port -> selectors 3,2,1,0 two cycles after accept; o_act high until the cycle after the 12th handshake; then IDLE.
REQ-035 Command d=8'b00_00_10_11 -> o_err pulses exactly 1 cycle; state stays IDLE; selectors unchanged.
REQ-036 Valid command with i_idle=0 for 5 cycles -> state stays WAIT and selectors unchanged for 5 cycles, then update the cycle after i_idle=1.
REQ-037 n=0 -> selectors update; o_act never asserts; o_c_r returns to 1.
REQ-038 With CORY_ROUTE4_PERM_OVF_EN defined, a 4th handshake on port 0 with n=3 -> one o_err pulse; asserting reset mid-RUN -> identity selectors, o_act=0.
